// File: rtl/control_unit.sv
// Instruction decoder for the single-cycle-issue core.
// Ports:
//   clk, reset (async, active-high), opcode[5:0] in;
//   out: PC sequencing (pc_increment_control, pc_control),
//   register/stack/memory write controls, ALU operand and op select,
//   flag latch, nine one-hot branch-condition selects, result mux select.
// Every output is a register loaded from the combinational decode.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       pc_increment_control,
    output logic [1:0] pc_control,
    output logic       general_register_write_enable,
    output logic       stack_write_enable,
    output logic       stack_control,
    output logic       write_data_enable,
    output logic [1:0] ALU_soure_2,
    output logic [1:0] ALU_control,
    output logic       flags_write_enable,
    output logic       jump_zero_control,
    output logic       jump_below_control,
    output logic       jump_below_equal_control,
    output logic       jump_above_control,
    output logic       jump_above_equal_control,
    output logic       jump_greater_control,
    output logic       jump_greater_equal_control,
    output logic       jump_less_control,
    output logic       jump_less_equal_control,
    output logic       memory_write_enable,
    output logic [1:0] general_register_result_select
);

    typedef struct packed {
        logic       pc_inc;
        logic [1:0] pc_ctl;
        logic       reg_we;
        logic       stk_we;
        logic       stk_pop;
        logic       wdata_reg;
        logic [1:0] alu_src2;
        logic [1:0] alu_op;
        logic       flags_we;
        // bit 0 = zero ... bit 8 = less_equal
        logic [8:0] jmp;
        logic       mem_we;
        logic [1:0] res_sel;
    } ctrl_t;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    always_comb begin
        ctrl_d        = '0;
        ctrl_d.pc_inc = 1'b1;
        case (opcode)
            6'h01: begin
                ctrl_d.reg_we  = 1'b1;
                ctrl_d.res_sel = 2'b10;
            end
            6'h02, 6'h03, 6'h04, 6'h05,
            6'h06, 6'h07, 6'h08, 6'h09: begin
                ctrl_d.reg_we   = 1'b1;
                ctrl_d.flags_we = 1'b1;
                // odd opcodes take the immediate as operand B
                ctrl_d.alu_src2 = {1'b0, opcode[0]};
                case (opcode)
                    6'h02, 6'h03: ctrl_d.alu_op = 2'b00;
                    6'h04, 6'h05: ctrl_d.alu_op = 2'b01;
                    6'h06, 6'h07: ctrl_d.alu_op = 2'b10;
                    default:      ctrl_d.alu_op = 2'b11;
                endcase
            end
            6'h0A, 6'h0B: begin
                ctrl_d.flags_we = 1'b1;
                ctrl_d.alu_op   = 2'b01;
                ctrl_d.alu_src2 = {1'b0, opcode[0]};
            end
            6'h0C: begin
                ctrl_d.reg_we  = 1'b1;
                ctrl_d.res_sel = 2'b01;
            end
            6'h0D: begin
                ctrl_d.mem_we    = 1'b1;
                ctrl_d.wdata_reg = 1'b1;
            end
            6'h0E: begin
                ctrl_d.stk_we    = 1'b1;
                ctrl_d.wdata_reg = 1'b1;
            end
            6'h0F: begin
                ctrl_d.stk_we  = 1'b1;
                ctrl_d.stk_pop = 1'b1;
                ctrl_d.reg_we  = 1'b1;
                ctrl_d.res_sel = 2'b11;
            end
            6'h10: ctrl_d.pc_ctl = 2'b01;
            6'h11, 6'h12, 6'h13, 6'h14, 6'h15,
            6'h16, 6'h17, 6'h18, 6'h19: begin
                ctrl_d.pc_ctl = 2'b11;
                ctrl_d.jmp    = 9'd1 << (opcode - 6'h11);
            end
            6'h1A: begin
                // return address (PC+1) goes onto the stack
                ctrl_d.pc_ctl = 2'b01;
                ctrl_d.stk_we = 1'b1;
            end
            6'h1B: begin
                ctrl_d.pc_ctl  = 2'b10;
                ctrl_d.stk_we  = 1'b1;
                ctrl_d.stk_pop = 1'b1;
            end
            6'h1C: ctrl_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign pc_increment_control           = ctrl_q.pc_inc;
    assign pc_control                     = ctrl_q.pc_ctl;
    assign general_register_write_enable  = ctrl_q.reg_we;
    assign stack_write_enable             = ctrl_q.stk_we;
    assign stack_control                  = ctrl_q.stk_pop;
    assign write_data_enable              = ctrl_q.wdata_reg;
    assign ALU_soure_2                    = ctrl_q.alu_src2;
    assign ALU_control                    = ctrl_q.alu_op;
    assign flags_write_enable             = ctrl_q.flags_we;
    assign jump_zero_control              = ctrl_q.jmp[0];
    assign jump_below_control             = ctrl_q.jmp[1];
    assign jump_below_equal_control       = ctrl_q.jmp[2];
    assign jump_above_control             = ctrl_q.jmp[3];
    assign jump_above_equal_control       = ctrl_q.jmp[4];
    assign jump_greater_control           = ctrl_q.jmp[5];
    assign jump_greater_equal_control     = ctrl_q.jmp[6];
    assign jump_less_control              = ctrl_q.jmp[7];
    assign jump_less_equal_control        = ctrl_q.jmp[8];
    assign memory_write_enable            = ctrl_q.mem_we;
    assign general_register_result_select = ctrl_q.res_sel;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: opcode sweep, HALT/undefined,
// async reset pulse and mid-cycle opcode change, with invariant checks.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       pc_inc;
    logic [1:0] pc_ctl;
    logic       grwe, swe, sc, wde;
    logic [1:0] src2, alu;
    logic       fwe;
    logic       jz, jb, jbe, ja, jae, jg, jge, jl, jle;
    logic       mwe;
    logic [1:0] rsel;

    int compared = 0;
    int mismatched = 0;

    control_unit dut (
        .clk                            (clk),
        .reset                          (reset),
        .opcode                         (opcode),
        .pc_increment_control           (pc_inc),
        .pc_control                     (pc_ctl),
        .general_register_write_enable  (grwe),
        .stack_write_enable             (swe),
        .stack_control                  (sc),
        .write_data_enable              (wde),
        .ALU_soure_2                    (src2),
        .ALU_control                    (alu),
        .flags_write_enable             (fwe),
        .jump_zero_control              (jz),
        .jump_below_control             (jb),
        .jump_below_equal_control       (jbe),
        .jump_above_control             (ja),
        .jump_above_equal_control       (jae),
        .jump_greater_control           (jg),
        .jump_greater_equal_control     (jge),
        .jump_less_control              (jl),
        .jump_less_equal_control        (jle),
        .memory_write_enable            (mwe),
        .general_register_result_select (rsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {inc, pcc, grwe, swe, sc, wde, src2, alu, fwe,
    //  jz jb jbe ja jae jg jge jl jle, mwe, rsel}
    function automatic logic [23:0] pk(
        input logic inc, input logic [1:0] pcc,
        input logic rw, input logic sw, input logic pop,
        input logic wd, input logic [1:0] s2, input logic [1:0] op,
        input logic fw, input logic [8:0] j, input logic mw,
        input logic [1:0] rs);
        return {inc, pcc, rw, sw, pop, wd, s2, op, fw, j, mw, rs};
    endfunction

    // Hand-written expected decode table
    function automatic logic [23:0] expv(input logic [5:0] o);
        case (o)
            6'h00: return pk(1,0,0,0,0,0,0,0,0,9'h000,0,0);
            6'h01: return pk(1,0,1,0,0,0,0,0,0,9'h000,0,2);
            6'h02: return pk(1,0,1,0,0,0,0,0,1,9'h000,0,0);
            6'h03: return pk(1,0,1,0,0,0,1,0,1,9'h000,0,0);
            6'h04: return pk(1,0,1,0,0,0,0,1,1,9'h000,0,0);
            6'h05: return pk(1,0,1,0,0,0,1,1,1,9'h000,0,0);
            6'h06: return pk(1,0,1,0,0,0,0,2,1,9'h000,0,0);
            6'h07: return pk(1,0,1,0,0,0,1,2,1,9'h000,0,0);
            6'h08: return pk(1,0,1,0,0,0,0,3,1,9'h000,0,0);
            6'h09: return pk(1,0,1,0,0,0,1,3,1,9'h000,0,0);
            6'h0A: return pk(1,0,0,0,0,0,0,1,1,9'h000,0,0);
            6'h0B: return pk(1,0,0,0,0,0,1,1,1,9'h000,0,0);
            6'h0C: return pk(1,0,1,0,0,0,0,0,0,9'h000,0,1);
            6'h0D: return pk(1,0,0,0,0,1,0,0,0,9'h000,1,0);
            6'h0E: return pk(1,0,0,1,0,1,0,0,0,9'h000,0,0);
            6'h0F: return pk(1,0,1,1,1,0,0,0,0,9'h000,0,3);
            6'h10: return pk(1,1,0,0,0,0,0,0,0,9'h000,0,0);
            6'h11: return pk(1,3,0,0,0,0,0,0,0,9'b100000000,0,0);
            6'h12: return pk(1,3,0,0,0,0,0,0,0,9'b010000000,0,0);
            6'h13: return pk(1,3,0,0,0,0,0,0,0,9'b001000000,0,0);
            6'h14: return pk(1,3,0,0,0,0,0,0,0,9'b000100000,0,0);
            6'h15: return pk(1,3,0,0,0,0,0,0,0,9'b000010000,0,0);
            6'h16: return pk(1,3,0,0,0,0,0,0,0,9'b000001000,0,0);
            6'h17: return pk(1,3,0,0,0,0,0,0,0,9'b000000100,0,0);
            6'h18: return pk(1,3,0,0,0,0,0,0,0,9'b000000010,0,0);
            6'h19: return pk(1,3,0,0,0,0,0,0,0,9'b000000001,0,0);
            6'h1A: return pk(1,1,0,1,0,0,0,0,0,9'h000,0,0);
            6'h1B: return pk(1,2,0,1,1,0,0,0,0,9'h000,0,0);
            6'h1C: return 24'h0;
            default: return pk(1,0,0,0,0,0,0,0,0,9'h000,0,0);
        endcase
    endfunction

    function automatic logic [23:0] obs();
        return {pc_inc, pc_ctl, grwe, swe, sc, wde, src2, alu, fwe,
                jz, jb, jbe, ja, jae, jg, jge, jl, jle, mwe, rsel};
    endfunction

    task automatic check(input string tag, input logic [23:0] e);
        logic [23:0] o;
        logic        inv;
        o = obs();
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
        // structural invariants on the same sample
        inv = !(mwe && grwe)
            && ((pc_ctl == 2'b11)
                || ({jz,jb,jbe,ja,jae,jg,jge,jl,jle} == 9'h0))
            && (src2[1] == 1'b0);
        compared++;
        assert (inv === 1'b1) else begin
            mismatched++;
            $error("FAIL %s_inv: observed %b expected 1", tag, inv);
        end
    endtask

    task automatic step(input logic [5:0] o);
        opcode = o;
        @(posedge clk);
        #1;
        check($sformatf("op%02h", o), expv(o));
    endtask

    initial begin
        reset  = 1'b0;
        opcode = 6'h0F;
        #1 reset = 1'b1;
        #1 check("reset_async", 24'h0);
        @(posedge clk);
        #1 check("reset_hold", 24'h0);

        // release between edges; first edge loads the decode
        opcode = 6'h00;
        reset  = 1'b0;
        #1 check("pre_edge", 24'h0);

        for (int i = 0; i <= 8'h1A; i++) begin
            step(6'(i));
        end
        step(6'h1B);

        // opcode change between edges leaves outputs alone
        step(6'h14);
        opcode = 6'h0D;
        #3 check("hold_14", expv(6'h14));
        @(posedge clk);
        #1 check("op0D_late", expv(6'h0D));

        step(6'h1C);
        step(6'h3F);
        step(6'h1D);
        step(6'h2A);
        step(6'h1C);
        step(6'h1A);

        // reset pulse mid-operation with POP pending
        step(6'h0F);
        #2 reset = 1'b1;
        #1 check("rst_pulse", 24'h0);
        #2 reset = 1'b0;
        #1 check("rst_released", 24'h0);
        @(posedge clk);
        #1 check("pop_back", expv(6'h0F));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
